pico_mem_responder: RTL and testbench

PICO_MEM_RESPONDER -- requirements
Module: pico_mem_responder

---
 rtl/pico_mem_responder.sv | 117 +++++++++++
 tb/tb_pico_mem_responder.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/pico_mem_responder.sv
// pico_mem_responder: SRAM responder for a core port, with optional arbitrated ext port
// enabled by defining PICO_MEM_RESPONDER_EXT_PORT_EN.
module pico_mem_responder #(
  parameter int PICO_MEM_DATA_SIZE = 32,
  parameter int PICO_MEM_ADDR_SIZE = 32,
  parameter int SRAM_ADDR_SIZE = 12,
  parameter int EXT_MAX_WAIT = 4
) (
  input  logic                            clk_i,
  input  logic                            resetn_i,
  input  logic                            mem_en_i,
  input  logic [PICO_MEM_DATA_SIZE/8-1:0] mem_we_i,
  input  logic [PICO_MEM_ADDR_SIZE-1:0]   mem_addr_i,
  input  logic [PICO_MEM_DATA_SIZE-1:0]   mem_wdata_i,
  output logic [PICO_MEM_DATA_SIZE-1:0]   mem_rdata_o,
  output logic                            mem_stall_o,
  output logic                            mem_err_o,
  output logic                            sram_en_o,
  output logic [PICO_MEM_DATA_SIZE/8-1:0] sram_we_o,
  output logic [SRAM_ADDR_SIZE-1:0]       sram_addr_o,
  output logic [PICO_MEM_DATA_SIZE-1:0]   sram_wdata_o,
  input  logic [PICO_MEM_DATA_SIZE-1:0]   sram_rdata_i
`ifdef PICO_MEM_RESPONDER_EXT_PORT_EN
  ,
  input  logic                            ext_req_i,
  input  logic [PICO_MEM_DATA_SIZE/8-1:0] ext_we_i,
  input  logic [PICO_MEM_ADDR_SIZE-1:0]   ext_addr_i,
  input  logic [PICO_MEM_DATA_SIZE-1:0]   ext_wdata_i,
  output logic                            ext_gnt_o,
  output logic                            ext_rvalid_o,
  output logic [PICO_MEM_DATA_SIZE-1:0]   ext_rdata_o
`endif
);
  localparam int HI = SRAM_ADDR_SIZE + 2;
`ifdef PICO_MEM_RESPONDER_EXT_PORT_EN
  localparam int WW = $clog2(EXT_MAX_WAIT + 1);
  typedef enum logic [1:0] {IDLE, CORE, EXT} state_e;
`else
  typedef enum logic {IDLE, CORE} state_e;
`endif
  state_e state_d, state_q;
  logic core_in, core_acc, core_pend, core_oor_rd;
  logic core_rd_d, core_rd_q, core_oor_d, core_oor_q;
  logic [PICO_MEM_DATA_SIZE-1:0] hold_d, hold_q;
  logic gnt;
  logic unused_ok;
  assign core_in = ~|mem_addr_i[PICO_MEM_ADDR_SIZE-1:HI];
`ifdef PICO_MEM_RESPONDER_EXT_PORT_EN
  logic ext_in, ext_rd_d, ext_rd_q, ext_oor_d, ext_oor_q;
  logic [WW-1:0] wait_d, wait_q;
  assign ext_in = ~|ext_addr_i[PICO_MEM_ADDR_SIZE-1:HI];
  // ext only pre-empts the core once it has waited the maximum number of cycles
  assign gnt = resetn_i & ext_req_i & (~mem_en_i | (wait_q == WW'(EXT_MAX_WAIT)));
  assign ext_gnt_o = gnt;
  assign unused_ok = ^{mem_addr_i[1:0], ext_addr_i[1:0]};
  always_comb begin
    wait_d = (~ext_req_i | gnt) ? '0 : (wait_q == WW'(EXT_MAX_WAIT)) ? wait_q : wait_q + 1'b1;
    ext_rd_d = ~|ext_we_i;
    ext_oor_d = ~ext_in;
    ext_rvalid_o = resetn_i & (state_q == EXT) & ext_rd_q;
    ext_rdata_o = (ext_rvalid_o & ~ext_oor_q) ? sram_rdata_i : '0;
  end
  always_ff @(posedge clk_i) begin
    if (!resetn_i) begin
      wait_q <= '0;
      ext_rd_q <= 1'b0;
      ext_oor_q <= 1'b0;
    end else begin
      wait_q <= wait_d;
      ext_rd_q <= ext_rd_d;
      ext_oor_q <= ext_oor_d;
    end
  end
`else
  assign gnt = 1'b0;
  assign unused_ok = ^{mem_addr_i[1:0], EXT_MAX_WAIT > 0};
`endif
  always_comb begin
    core_acc = resetn_i & mem_en_i & ~gnt;
`ifdef PICO_MEM_RESPONDER_EXT_PORT_EN
    mem_stall_o = mem_en_i & gnt;
    sram_en_o = gnt ? ext_in : core_acc & core_in;
    sram_we_o = ~sram_en_o ? '0 : gnt ? ext_we_i : mem_we_i;
    sram_addr_o = gnt ? ext_addr_i[HI-1:2] : mem_addr_i[HI-1:2];
    sram_wdata_o = gnt ? ext_wdata_i : mem_wdata_i;
    state_d = gnt ? EXT : core_acc ? CORE : IDLE;
`else
    mem_stall_o = 1'b0;
    sram_en_o = core_acc & core_in;
    sram_we_o = sram_en_o ? mem_we_i : '0;
    sram_addr_o = mem_addr_i[HI-1:2];
    sram_wdata_o = mem_wdata_i;
    state_d = core_acc ? CORE : IDLE;
`endif
    core_rd_d = ~|mem_we_i;
    core_oor_d = ~core_in;
    core_pend = resetn_i & (state_q == CORE) & core_rd_q & ~core_oor_q;
    core_oor_rd = resetn_i & (state_q == CORE) & core_rd_q & core_oor_q;
    mem_err_o = resetn_i & (state_q == CORE) & core_oor_q;
    // only a completing core read updates the held data; ext and writes leave it
    hold_d = core_pend ? sram_rdata_i : core_oor_rd ? '0 : hold_q;
    mem_rdata_o = resetn_i ? hold_d : '0;
  end
  always_ff @(posedge clk_i) begin
    if (!resetn_i) begin
      state_q <= IDLE;
      core_rd_q <= 1'b0;
      core_oor_q <= 1'b0;
      hold_q <= '0;
    end else begin
      state_q <= state_d;
      core_rd_q <= core_rd_d;
      core_oor_q <= core_oor_d;
      hold_q <= hold_d;
    end
  end
endmodule

// File: tb/tb_pico_mem_responder.sv
// tb_pico_mem_responder: vector table, reset/ext sequences and random traffic vs a word-level model
module tb_pico_mem_responder;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic resetn, mem_en, mem_stall, mem_err, sram_en;
  logic [3:0] mem_we, sram_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata, sram_wdata, sram_rdata;
  logic [11:0] sram_addr;
  logic [31:0] sram [4096];
  int total = 0, bad = 0;
`ifdef PICO_MEM_RESPONDER_EXT_PORT_EN
  logic ext_req, ext_gnt, ext_rvalid, nx_req;
  logic [3:0] ext_we, nx_we;
  logic [31:0] ext_addr, ext_wdata, ext_rdata, nx_addr, nx_wdata;
`endif
  pico_mem_responder dut (
    .clk_i(clk), .resetn_i(resetn), .mem_en_i(mem_en), .mem_we_i(mem_we),
    .mem_addr_i(mem_addr), .mem_wdata_i(mem_wdata), .mem_rdata_o(mem_rdata),
    .mem_stall_o(mem_stall), .mem_err_o(mem_err), .sram_en_o(sram_en),
    .sram_we_o(sram_we), .sram_addr_o(sram_addr), .sram_wdata_o(sram_wdata),
    .sram_rdata_i(sram_rdata)
`ifdef PICO_MEM_RESPONDER_EXT_PORT_EN
    , .ext_req_i(ext_req), .ext_we_i(ext_we), .ext_addr_i(ext_addr),
    .ext_wdata_i(ext_wdata), .ext_gnt_o(ext_gnt), .ext_rvalid_o(ext_rvalid),
    .ext_rdata_o(ext_rdata)
`endif
  );
  always @(posedge clk) begin
    if (sram_en) begin
      sram_rdata <= sram[sram_addr];
      for (int b = 0; b < 4; b++)
        if (sram_we[b]) sram[sram_addr][8*b +: 8] <= sram_wdata[8*b +: 8];
    end else sram_rdata <= $urandom;
  end
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask
  task automatic cyc(input logic rn, input logic en, input logic [3:0] we, input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    resetn = rn;
    mem_en = en;
    mem_we = we;
    mem_addr = a;
    mem_wdata = d;
`ifdef PICO_MEM_RESPONDER_EXT_PORT_EN
    ext_req = nx_req;
    ext_we = nx_we;
    ext_addr = nx_addr;
    ext_wdata = nx_wdata;
`endif
    #1;
  endtask
  typedef struct {
    logic en; logic [3:0] we; logic [31:0] addr; logic [31:0] wdata;
    logic x_en; logic [31:0] x_rd; logic x_err;
  } vec_t;
  vec_t tab [14];
  logic [31:0] rm [16];
  logic [31:0] exp_rd, a, d;
  logic exp_err, en, inr;
  logic [3:0] we;
  initial begin
    for (int i = 0; i < 4096; i++) sram[i] = '0;
    for (int i = 0; i < 16; i++) rm[i] = '0;
    resetn = 1'b0; mem_en = 1'b0; mem_we = '0; mem_addr = '0; mem_wdata = '0;
`ifdef PICO_MEM_RESPONDER_EXT_PORT_EN
    nx_req = 1'b0; nx_we = '0; nx_addr = '0; nx_wdata = '0;
    ext_req = 1'b0; ext_we = '0; ext_addr = '0; ext_wdata = '0;
`endif
    tab[0]  = '{1'b1, 4'hF, 32'h40,   32'hA5A51234, 1'b1, 32'h0,        1'b0};
    tab[1]  = '{1'b1, 4'h0, 32'h40,   32'h0,        1'b1, 32'hA5A51234, 1'b0};
    tab[2]  = '{1'b1, 4'hF, 32'h100,  32'h11223344, 1'b1, 32'hA5A51234, 1'b0};
    tab[3]  = '{1'b1, 4'h1, 32'h100,  32'h000000FF, 1'b1, 32'hA5A51234, 1'b0};
    tab[4]  = '{1'b1, 4'h0, 32'h102,  32'h0,        1'b1, 32'h112233FF, 1'b0};
    tab[5]  = '{1'b1, 4'h0, 32'h4000, 32'h0,        1'b0, 32'h0,        1'b1};
    tab[6]  = '{1'b0, 4'h0, 32'h0,    32'h0,        1'b0, 32'h0,        1'b0};
    tab[7]  = '{1'b1, 4'hF, 32'h4000, 32'hDEADBEEF, 1'b0, 32'h0,        1'b1};
    tab[8]  = '{1'b1, 4'h0, 32'h0,    32'h0,        1'b1, 32'h0,        1'b0};
    tab[9]  = '{1'b1, 4'h0, 32'h100,  32'h0,        1'b1, 32'h112233FF, 1'b0};
    tab[10] = '{1'b0, 4'h0, 32'h0,    32'h0,        1'b0, 32'h112233FF, 1'b0};
    tab[11] = '{1'b1, 4'h2, 32'h100,  32'h0000AB00, 1'b1, 32'h112233FF, 1'b0};
    tab[12] = '{1'b1, 4'h0, 32'h100,  32'h0,        1'b1, 32'h1122ABFF, 1'b0};
    tab[13] = '{1'b0, 4'h0, 32'h0,    32'h0,        1'b0, 32'h1122ABFF, 1'b0};
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 1'b1, 4'h0, 32'h40, 32'h0);
      chk("reset sram_en", sram_en, 1'b0);
      chk("reset stall", mem_stall, 1'b0);
      chk("reset err", mem_err, 1'b0);
      chk("reset rdata", mem_rdata, 32'h0);
    end
    for (int i = 0; i < 14; i++) begin
      cyc(1'b1, tab[i].en, tab[i].we, tab[i].addr, tab[i].wdata);
      if (i > 0) begin
        chk($sformatf("tab%0d rdata", i - 1), mem_rdata, tab[i-1].x_rd);
        chk($sformatf("tab%0d err", i - 1), mem_err, tab[i-1].x_err);
      end
      chk($sformatf("tab%0d sram_en", i), sram_en, tab[i].x_en);
      chk($sformatf("tab%0d stall", i), mem_stall, 1'b0);
      if (tab[i].x_en) begin
        chk($sformatf("tab%0d sram_addr", i), sram_addr, tab[i].addr[13:2]);
        chk($sformatf("tab%0d sram_we", i), sram_we, tab[i].we);
        if (tab[i].we != 0) chk($sformatf("tab%0d sram_wdata", i), sram_wdata, tab[i].wdata);
      end
    end
    cyc(1'b1, 1'b1, 4'h0, 32'h40, 32'h0);
    chk("rst-mid issue", sram_en, 1'b1);
    cyc(1'b0, 1'b1, 4'h0, 32'h4000, 32'h0);
    chk("rst-mid sram_en", sram_en, 1'b0);
    chk("rst-mid err", mem_err, 1'b0);
    chk("rst-mid stall", mem_stall, 1'b0);
    cyc(1'b1, 1'b0, 4'h0, 32'h0, 32'h0);
    chk("post-rst rdata", mem_rdata, 32'h0);
    chk("post-rst err", mem_err, 1'b0);
    cyc(1'b1, 1'b1, 4'h0, 32'h40, 32'h0);
    chk("post-rst accept", sram_en, 1'b1);
    cyc(1'b1, 1'b1, 4'h0, 32'h4000, 32'h0);
    chk("post-rst rdata2", mem_rdata, 32'hA5A51234);
    cyc(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    chk("rst-oor err", mem_err, 1'b0);
    cyc(1'b1, 1'b0, 4'h0, 32'h0, 32'h0);
    chk("rst-oor err2", mem_err, 1'b0);
    chk("rst-oor rdata", mem_rdata, 32'h0);
`ifdef PICO_MEM_RESPONDER_EXT_PORT_EN
    for (int c = 1; c <= 6; c++) begin
      nx_req = c < 6; nx_we = 4'h0; nx_addr = 32'h100;
      cyc(1'b1, c < 6, 4'h0, 32'h40, 32'h0);
      if (c < 6) begin
        chk($sformatf("starve gnt c%0d", c), ext_gnt, c == 5);
        chk($sformatf("starve stall c%0d", c), mem_stall, c == 5);
      end
      if (c == 5) chk("starve ext addr", sram_addr, 12'h040);
      if (c > 1) chk($sformatf("starve rdata c%0d", c), mem_rdata, 32'hA5A51234);
      chk($sformatf("starve rvalid c%0d", c), ext_rvalid, c == 6);
      if (c == 6) chk("starve ext rdata", ext_rdata, 32'h1122ABFF);
    end
    nx_req = 1'b0;
    cyc(1'b1, 1'b1, 4'h0, 32'h100, 32'h0);
    chk("ext A gnt", ext_gnt, 1'b0);
    nx_req = 1'b1; nx_we = 4'hF; nx_addr = 32'h40; nx_wdata = 32'h5555AAAA;
    cyc(1'b1, 1'b0, 4'h0, 32'h0, 32'h0);
    chk("ext B gnt", ext_gnt, 1'b1);
    chk("ext B we", sram_we, 4'hF);
    chk("ext B addr", sram_addr, 12'h010);
    chk("ext B core rdata", mem_rdata, 32'h1122ABFF);
    nx_we = 4'h0; nx_addr = 32'h4000;
    cyc(1'b1, 1'b0, 4'h0, 32'h0, 32'h0);
    chk("ext C gnt", ext_gnt, 1'b1);
    chk("ext C oor en", sram_en, 1'b0);
    chk("ext C rvalid", ext_rvalid, 1'b0);
    chk("ext C core rdata", mem_rdata, 32'h1122ABFF);
    nx_req = 1'b0;
    cyc(1'b1, 1'b1, 4'h0, 32'h40, 32'h0);
    chk("ext D rvalid", ext_rvalid, 1'b1);
    chk("ext D oor rdata", ext_rdata, 32'h0);
    chk("ext D core en", sram_en, 1'b1);
    cyc(1'b1, 1'b0, 4'h0, 32'h0, 32'h0);
    chk("ext E core rdata", mem_rdata, 32'h5555AAAA);
    chk("ext E rvalid", ext_rvalid, 1'b0);
`endif
    cyc(1'b1, 1'b1, 4'h0, 32'h4000, 32'h0);
    exp_rd = '0;
    exp_err = 1'b1;
    for (int n = 0; n < 400; n++) begin
      en = $urandom_range(0, 3) != 0;
      we = $urandom_range(0, 1) ? 4'($urandom) : 4'h0;
      a = ($urandom_range(0, 7) == 0) ? ($urandom | (32'h1 << $urandom_range(14, 31)))
                                       : 32'h80 + 4 * $urandom_range(0, 15) + $urandom_range(0, 3);
      d = $urandom;
      inr = a < 32'h4000;
      cyc(1'b1, en, we, a, d);
      chk($sformatf("rnd%0d rdata", n), mem_rdata, exp_rd);
      chk($sformatf("rnd%0d err", n), mem_err, exp_err);
      chk($sformatf("rnd%0d sram_en", n), sram_en, en && inr);
      if (en && inr) chk($sformatf("rnd%0d sram_addr", n), sram_addr, (a >> 2) & 32'hFFF);
      exp_err = en && !inr;
      if (en && we == 0) exp_rd = inr ? rm[(a - 32'h80) >> 2] : 32'h0;
      if (en && we != 0 && inr)
        for (int b = 0; b < 4; b++)
          if (we[b]) rm[(a - 32'h80) >> 2][8*b +: 8] = d[8*b +: 8];
    end
    cyc(1'b1, 1'b0, 4'h0, 32'h0, 32'h0);
    chk("rnd final rdata", mem_rdata, exp_rd);
    chk("rnd final err", mem_err, exp_err);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
